// File: rtl/fetch_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_pkg : state/redirect-source types and exception causes for fetch  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [2:0] {
    RESET = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_TRAP = 2'd1,
    REDIR_MRET = 2'd2,
    REDIR_BR   = 2'd3
  } redir_src_e;

  localparam int                  CAUSE_W                = 4;
  localparam logic [CAUSE_W-1:0]  CAUSE_INSTR_MISALIGNED = 4'd0;

endpackage
`default_nettype wire

// File: rtl/redirect_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | redirect_arbiter : fixed-priority redirect select (trap > mret > br);   |
// | FETCH_MISALIGN_TRAP_EN turns misaligned mret/br targets into a trap.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int TRAP_CAUSE_W = 4
) (
  input  logic                    br_taken,
  input  logic [XLEN-1:0]         br_target,
  input  logic                    trap_req,
  input  logic [XLEN-1:0]         trap_vec,
  input  logic                    mret_req,
  input  logic [XLEN-1:0]         mepc,
  output redir_src_e              src,
  output logic [XLEN-1:0]         target,
  output logic                    exc_valid,
  output logic [TRAP_CAUSE_W-1:0] exc_cause
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    src        = REDIR_NONE;
    raw_target = '0;
    if (trap_req) begin
      src        = REDIR_TRAP;
      raw_target = trap_vec;
    end else if (mret_req) begin
      src        = REDIR_MRET;
      raw_target = mepc;
    end else if (br_taken) begin
      src        = REDIR_BR;
      raw_target = br_target;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned trap vector is trusted; only mret/branch targets are checked.
  logic misaligned;
  assign misaligned = ((src == REDIR_MRET) || (src == REDIR_BR)) && (raw_target[1:0] != 2'b00);
  assign target     = misaligned ? trap_vec : raw_target;
  assign exc_valid  = misaligned;
`else
  assign target     = raw_target;
  assign exc_valid  = 1'b0;
`endif

  assign exc_cause = TRAP_CAUSE_W'(CAUSE_INSTR_MISALIGNED);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_sequencer : PC advance/load control and single-outstanding fetch  |
// | handshake; optional FETCH_MISALIGN_TRAP_EN misaligned-target trap.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int TRAP_CAUSE_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         pc_curr,
  output logic                    pc_en,
  output logic                    pc_load_en,
  output logic [XLEN-1:0]         pc_load_val,
  output logic                    imem_req,
  output logic [XLEN-1:0]         imem_addr,
  input  logic                    imem_gnt,
  input  logic                    imem_rvalid,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    instr_valid,
  output logic [XLEN-1:0]         instr_data,
  output logic [XLEN-1:0]         instr_pc,
  input  logic                    dec_ready,
  input  logic                    br_taken,
  input  logic [XLEN-1:0]         br_target,
  input  logic                    trap_req,
  input  logic [XLEN-1:0]         trap_vec,
  input  logic                    mret_req,
  input  logic [XLEN-1:0]         mepc,
  output logic                    exc_valid,
  output logic [TRAP_CAUSE_W-1:0] exc_cause
);

  fetch_state_e            state;
  logic [XLEN-1:0]         req_pc;
  redir_src_e              redir_src;
  logic [XLEN-1:0]         redir_target;
  logic                    redir_exc;
  logic [TRAP_CAUSE_W-1:0] redir_cause;
  logic                    redirect;

  redirect_arbiter #(
    .XLEN         (XLEN),
    .TRAP_CAUSE_W (TRAP_CAUSE_W)
  ) u_redirect_arbiter (
    .br_taken  (br_taken),
    .br_target (br_target),
    .trap_req  (trap_req),
    .trap_vec  (trap_vec),
    .mret_req  (mret_req),
    .mepc      (mepc),
    .src       (redir_src),
    .target    (redir_target),
    .exc_valid (redir_exc),
    .exc_cause (redir_cause)
  );

  assign redirect    = (state != RESET) && (redir_src != REDIR_NONE);
  assign imem_req    = (state == REQ);
  assign imem_addr   = imem_req ? pc_curr : '0;
  // A load always beats an advance in the same cycle.
  assign pc_en       = imem_req && imem_gnt && !redirect;
  assign pc_load_en  = redirect;
  assign pc_load_val = redirect ? redir_target : '0;
  assign exc_valid   = redirect && redir_exc;
  assign exc_cause   = exc_valid ? redir_cause : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RESET;
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        RESET: state <= REQ;
        REQ: begin
          // A granted request that is redirected still owes us a response.
          if (redirect) begin
            state <= imem_gnt ? DRAIN : REQ;
          end else if (imem_gnt) begin
            req_pc <= pc_curr;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            state <= imem_rvalid ? REQ : DRAIN;
          end else if (imem_rvalid) begin
            instr_valid <= 1'b1;
            instr_data  <= imem_rdata;
            instr_pc    <= req_pc;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect || dec_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state <= REQ;
        end
        default: begin
          instr_valid <= 1'b0;
          state       <= RESET;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fetch_sequencer : directed + randomized bench with scoreboard queue  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_curr;
  logic        pc_en, pc_load_en;
  logic [31:0] pc_load_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data, instr_pc;
  logic        dec_ready, br_taken, trap_req, mret_req;
  logic [31:0] br_target, trap_vec, mepc;
  logic        exc_valid;
  logic [3:0]  exc_cause;

  fetch_sequencer #(.XLEN(32), .TRAP_CAUSE_W(4)) dut (
    .clk(clk), .rst(rst), .pc_curr(pc_curr),
    .pc_en(pc_en), .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .br_taken(br_taken), .br_target(br_target),
    .trap_req(trap_req), .trap_vec(trap_vec), .mret_req(mret_req), .mepc(mepc),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  // Program counter of the surrounding core, driven only by the DUT's strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc_curr <= RESET_PC;
    else if (pc_load_en) pc_curr <= pc_load_val;
    else if (pc_en)      pc_curr <= pc_curr + 32'd4;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          delivered = 0;
  exp_t        exp_q[$];
  // Reference model: transaction-level view of the fetch stream.
  bit          outstanding, live, pending, boot;
  logic [31:0] exp_pc, resp_addr;
  int          resp_delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  function automatic void winner(input bit b, input bit t, input bit m,
                                 output logic [31:0] w, output bit exc);
    exc = 1'b0;
    if (t)      w = trap_vec;
    else if (m) w = mepc;
    else        w = br_target;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (!t && (m || b) && (w & 32'd3) != 32'd0) begin
      w   = trap_vec;
      exc = 1'b1;
    end
`endif
  endfunction

  // Monitor: pops one expected instruction every time a new one is presented.
  logic        prev_valid;
  logic [31:0] prev_pc, prev_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_instr: got pc %h data %h, expected no instruction", instr_pc, instr_data);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr_data", instr_data, e.data);
          delivered++;
        end
      end else if (instr_valid && prev_valid) begin
        chk("hold_pc_stable", instr_pc, prev_pc);
        chk("hold_data_stable", instr_data, prev_data);
      end
      prev_valid <= instr_valid;
      prev_pc    <= instr_pc;
      prev_data  <= instr_data;
    end
  end

  // One clock: drive inputs just after posedge, check at negedge, update model.
  task automatic cycle(input bit g, input bit rv, input bit dr,
                       input bit b, input bit t, input bit m, input logic [31:0] rd);
    logic [31:0] w;
    bit          exc_e, redir, req_e;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; dec_ready = dr;
    br_taken = b; trap_req = t; mret_req = m;
    @(negedge clk);
    redir = !boot && (b || t || m);
    winner(b, t, m, w, exc_e);
    exc_e = exc_e && redir;
    req_e = !outstanding && !pending && !boot;
    chk1("imem_req", imem_req, req_e);
    if (req_e) chk("imem_addr", imem_addr, exp_pc);
    chk1("instr_valid", instr_valid, pending);
    chk1("pc_en", pc_en, req_e && g && !redir);
    chk1("pc_load_en", pc_load_en, redir);
    if (redir) chk("pc_load_val", pc_load_val, w);
    chk1("exc_valid", exc_valid, exc_e);
    if (exc_e) chk("exc_cause", {28'd0, exc_cause}, 32'd0);
    if (pending && (dr || redir)) pending = 1'b0;
    if (redir) live = 1'b0;
    if (rv && outstanding) begin
      if (live) begin
        exp_q.push_back('{pc: resp_addr, data: rd});
        pending = 1'b1;
      end
      outstanding = 1'b0;
    end
    if (req_e && g) begin
      outstanding = 1'b1;
      resp_addr   = exp_pc;
      live        = !redir;
      resp_delay  = $urandom_range(0, 3);
      if (!redir) exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = w;
    boot = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; dec_ready = 0;
    br_taken = 0; trap_req = 0; mret_req = 0;
    exp_q.delete();
    outstanding = 0; pending = 0; live = 0;
    #1;
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_pc_load_en", pc_load_en, 1'b0);
    chk("rst_pc_load_val", pc_load_val, 32'd0);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data", instr_data, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk1("rst_exc_valid", exc_valid, 1'b0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    boot   = 1'b1;
    exp_pc = RESET_PC;
  endtask

  initial begin
    rst = 1'b0;
    br_target = '0; trap_vec = '0; mepc = '0;
    boot = 0; resp_delay = 0;
    #2;
    do_reset();

    // Basic fetch: grant next cycle, response two cycles after grant.
    cycle(0, 0, 0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 0, 32'h0000_0013);
    cycle(0, 0, 1, 0, 0, 0, '0);
    chk("next_fetch_addr", imem_addr, 32'h8000_0004);

    // Decode stall for five cycles.
    cycle(1, 0, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 0, 32'h0010_0093);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, 0, '0);
    chk1("resume_after_stall", imem_req, 1'b1);

    // Branch while waiting; the in-flight response must be dropped.
    cycle(1, 0, 0, 0, 0, 0, '0);
    br_target = 32'h8000_0100;
    cycle(0, 0, 0, 1, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("after_branch_addr", imem_addr, 32'h8000_0100);

    // All three redirect sources at once: trap wins.
    trap_vec = 32'h8000_0200; mepc = 32'h8000_0300; br_target = 32'h8000_0400;
    cycle(0, 0, 0, 1, 1, 1, '0);
    chk("after_trap_addr", imem_addr, 32'h8000_0200);

    // Reset while waiting, then a late response.
    cycle(1, 0, 0, 0, 0, 0, '0);
    do_reset();
    cycle(0, 1, 0, 0, 0, 0, 32'h1234_5678);
    cycle(0, 1, 0, 0, 0, 0, 32'h1234_5678);

    // Misaligned branch target.
    br_target = 32'h8000_0102; trap_vec = 32'h8000_0200;
    cycle(0, 0, 0, 1, 0, 0, '0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_addr", imem_addr, 32'h8000_0200);
`else
    chk("misalign_addr", imem_addr, 32'h8000_0102);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit g, rv, dr, b, t, m;
      rv = 1'b0;
      if (outstanding) begin
        if (resp_delay == 0) rv = 1'b1;
        else resp_delay--;
      end
      g  = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 1) == 1);
      b  = ($urandom_range(0, 15) == 0);
      t  = ($urandom_range(0, 31) == 0);
      m  = ($urandom_range(0, 23) == 0);
      br_target = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) br_target = br_target | $urandom_range(1, 3);
      mepc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) mepc = mepc | $urandom_range(1, 3);
      trap_vec = $urandom() & 32'hFFFF_FFFC;
      cycle(g, rv, dr, b, t, m, $urandom());
    end

    // Drain: no new grants, decode always ready.
    for (int i = 0; i < 12; i++) begin
      bit rv;
      rv = 1'b0;
      if (outstanding) begin
        if (resp_delay == 0) rv = 1'b1;
        else resp_delay--;
      end
      cycle(0, rv, 1, 0, 0, 0, $urandom());
    end
    chk1("queue_drained", exp_q.size() == 0, 1'b1);
    chk1("enough_delivered", delivered > 50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
